hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor of the EX-stage operand forwarding logic in the pipelined MIPS core. It adds three things: N forwarding source stages, load-use hazard detection with a multi-cycle stall FSM, and a saturating stall-cycle performance counter.
- Sits between the ID/EX pipeline registers and the pipeline control (PC write, IF/ID hold, ID/EX bubble). It drives the ALU operand muxes.

Parameters:
- REG_ADDR_W, 5, register-number width.
- NUM_STAGES, 2, number of forwarding sources. Index 0 is the youngest (MEM); index NUM_STAGES-1 is the oldest (WB).
- SEL_W, 2, width of each forward select. Must satisfy SEL_W >= clog2(NUM_STAGES+1).
- LEGACY_ENC, 1, 1 = legacy select encoding (NUM_STAGES must be 2); 0 = index encoding.
- LOAD_LAT, 1, stall cycles per load-use hazard. Must be >= 1.
- CNT_W, 16, stall-counter width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  pipeline advance enable (debug unit); 0 freezes the FSM and the counter.
- i_rs_EX  in  REG_ADDR_W  rs of the instruction in EX.
- i_rt_EX  in  REG_ADDR_W  rt of the instruction in EX.
- i_rd_stage  in  NUM_STAGES*REG_ADDR_W  destination reg per source stage; stage k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- i_regwrite_stage  in  NUM_STAGES  regwrite per source stage.
- i_rs_ID  in  REG_ADDR_W  rs of the instruction in ID.
- i_rt_ID  in  REG_ADDR_W  rt of the instruction in ID.
- i_uses_rs_ID  in  1  ID instruction reads rs.
- i_uses_rt_ID  in  1  ID instruction reads rt.
- i_memread_EX  in  1  EX instruction is a load.
- i_rd_EX  in  REG_ADDR_W  load destination in EX.
- i_clr_count  in  1  synchronous clear of the stall counter.
- o_forward_a  out  SEL_W  operand-A mux select.
- o_forward_b  out  SEL_W  operand-B mux select.
- o_stall  out  1  hold PC and IF/ID.
- o_flush_ID_EX  out  1  insert a bubble into ID/EX.
- o_stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding is combinational with zero latency.
  - For operand A, scan k = 0..NUM_STAGES-1 and take the first k with i_regwrite_stage[k], rd_k != 0 and rd_k == i_rs_EX. Operand B does the same against i_rt_EX.
  - The youngest matching stage always wins.
  - No match gives select 0.
- Select encoding:
  - LEGACY_ENC=1: stage 0 = 2'b10, stage 1 = 2'b01, none = 2'b00.
  - LEGACY_ENC=0: select = k+1.
- Register 0 is never forwarded, regardless of regwrite.
- Hazard detect (combinational):
  - hz = i_memread_EX && i_rd_EX != 0 && ((i_uses_rs_ID && i_rd_EX == i_rs_ID) || (i_uses_rt_ID && i_rd_EX == i_rt_ID)).
- FSM states are IDLE and STALL, with a down-counter cnt of width clog2(LOAD_LAT+1).
  - IDLE: o_stall = hz. If hz, i_enable and LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT-1. Otherwise remain in IDLE.
  - STALL: o_stall = 1 and hz is ignored, because the EX slot holds a bubble. On each edge with i_enable, cnt decrements; when cnt == 1, go to IDLE.
  - i_enable = 0: state and cnt hold; o_stall keeps its current combinational value.
  - Result: each hazard stalls exactly LOAD_LAT enabled cycles.
- o_flush_ID_EX = o_stall in every state.
- Stall counter:
  - Increments on each edge where o_stall && i_enable && the count is not all ones. It saturates at 2^CNT_W-1 and never wraps.
  - If i_clr_count is high on the same edge as an increment, clear wins and the result is 0.
- Reset (i_reset == 0 at the edge):
  - state = IDLE, cnt = 0, o_stall_count = 0.
  - While i_reset is low, all combinational outputs are forced to 0: o_forward_a, o_forward_b, o_stall, o_flush_ID_EX.
  - Reset mid-STALL aborts the stall; after reset is released the unit is in IDLE.
- No X-propagation: with all inputs 0, every output is 0.

Decomposition:
- Shared package/header holds:
  - FWD_NONE constant.
  - Legacy select constants FWD_MEM = 2'b10 and FWD_WB = 2'b01.
  - FSM state encoding ST_IDLE / ST_STALL.
- Sub-module fwd_select:
  - Parametrised by REG_ADDR_W, NUM_STAGES, SEL_W and LEGACY_ENC.
  - One priority scan for one source operand; instantiated twice (rs_EX, rt_EX).
- FSM and counter live in the top module.

Test Plan:
- Priority, NUM_STAGES=2, LEGACY_ENC=1. Stimulus: rd_stage0 = rd_stage1 = 8, both regwrite, rs_EX = 8, rt_EX = 3. Response: o_forward_a = 2'b10, o_forward_b = 2'b00. Then drop regwrite_stage0 -> o_forward_a = 2'b01.
- Register 0. Stimulus: rd_stage0 = 0, regwrite = 1, rs_EX = rt_EX = 0. Response: both selects = 0.
- Generic encoding, NUM_STAGES=3, LEGACY_ENC=0. Stimulus: only stage 2 matches rt_EX = 12. Response: o_forward_b = 3. Then add a stage 1 match -> o_forward_b = 2.
- Load-use stall, LOAD_LAT=3. Stimulus: memread_EX, rd_EX = 5, rs_ID = 5, uses_rs_ID, for one cycle.
  - Response: o_stall and o_flush_ID_EX high for exactly 3 cycles; o_stall_count = 3.
  - Repeat with uses_rs_ID = 0 -> no stall.
- Freeze and reset. Stimulus: during STALL with cnt = 2, hold i_enable = 0 for 4 cycles.
  - Response: o_stall stays 1 and o_stall_count is unchanged.
  - Then assert i_reset = 0 -> o_stall = 0 immediately; after release the FSM is IDLE and o_stall_count = 0.
- Counter saturation, CNT_W=4. Stimulus: hold a hazard pattern for 20 stall cycles.
  - Response: o_stall_count stops at 15.
  - Assert i_clr_count together with an increment -> o_stall_count = 0.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding unit.
//   FWD_NONE          : operand mux select when no stage forwards
//   FWD_MEM / FWD_WB  : legacy two-stage select codes
//   ST_IDLE / ST_STALL: load-use stall FSM state encoding
package hazard_forward_unit_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_STALL = 1'b1;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority forwarding scan for one EX source operand.
//   i_src            : source register number of the EX instruction
//   i_rd_stage       : packed destination registers, stage k at [k*REG_ADDR_W +: REG_ADDR_W]
//   i_regwrite_stage : regwrite flag per stage
//   o_sel            : operand mux select (legacy or index encoding)
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter int LEGACY_ENC = 1
) (
  input  logic [REG_ADDR_W-1:0]            i_src,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] i_rd_stage,
  input  logic [NUM_STAGES-1:0]            i_regwrite_stage,
  output logic [SEL_W-1:0]                 o_sel
);

  logic [REG_ADDR_W-1:0] rd_k;

  // Scan from the oldest stage to the youngest so a younger match overwrites
  // an older one; the youngest matching stage therefore wins.
  always_comb begin
    o_sel = SEL_W'(FWD_NONE);
    rd_k  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      rd_k = i_rd_stage[k*REG_ADDR_W +: REG_ADDR_W];
      // Register 0 is hard-wired zero and is never forwarded.
      if (i_regwrite_stage[k] && (rd_k != '0) && (rd_k == i_src)) begin
        if (LEGACY_ENC != 0) begin
          o_sel = (k == 0) ? SEL_W'(FWD_MEM) : SEL_W'(FWD_WB);
        end else begin
          o_sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding, load-use hazard stall FSM and a saturating
// stall-cycle counter.
//   i_clk, i_reset (sync, active-low), i_enable (0 freezes FSM and counter)
//   i_rs_EX/i_rt_EX, i_rd_stage/i_regwrite_stage : forwarding inputs
//   i_rs_ID/i_rt_ID/i_uses_*_ID, i_memread_EX, i_rd_EX : hazard inputs
//   i_clr_count : synchronous clear of the stall counter
//   o_forward_a/o_forward_b : ALU operand mux selects
//   o_stall (hold PC and IF/ID), o_flush_ID_EX (bubble), o_stall_count
// Handshake: none; every output is a plain level valid in the current cycle.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter int LEGACY_ENC = 1,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic [REG_ADDR_W-1:0]           i_rs_EX,
  input  logic [REG_ADDR_W-1:0]           i_rt_EX,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] i_rd_stage,
  input  logic [NUM_STAGES-1:0]           i_regwrite_stage,
  input  logic [REG_ADDR_W-1:0]           i_rs_ID,
  input  logic [REG_ADDR_W-1:0]           i_rt_ID,
  input  logic                            i_uses_rs_ID,
  input  logic                            i_uses_rt_ID,
  input  logic                            i_memread_EX,
  input  logic [REG_ADDR_W-1:0]           i_rd_EX,
  input  logic                            i_clr_count,
  output logic [SEL_W-1:0]                o_forward_a,
  output logic [SEL_W-1:0]                o_forward_b,
  output logic                            o_stall,
  output logic                            o_flush_ID_EX,
  output logic [CNT_W-1:0]                o_stall_count
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  logic [SEL_W-1:0] fwd_a_raw;
  logic [SEL_W-1:0] fwd_b_raw;
  logic             hz;
  logic             stall_raw;

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  hazard_forward_unit_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W),
    .LEGACY_ENC (LEGACY_ENC)
  ) u_fwd_a (
    .i_src            (i_rs_EX),
    .i_rd_stage       (i_rd_stage),
    .i_regwrite_stage (i_regwrite_stage),
    .o_sel            (fwd_a_raw)
  );

  hazard_forward_unit_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W),
    .LEGACY_ENC (LEGACY_ENC)
  ) u_fwd_b (
    .i_src            (i_rt_EX),
    .i_rd_stage       (i_rd_stage),
    .i_regwrite_stage (i_regwrite_stage),
    .o_sel            (fwd_b_raw)
  );

  always_comb begin
    hz = i_memread_EX && (i_rd_EX != '0) &&
         ((i_uses_rs_ID && (i_rd_EX == i_rs_ID)) ||
          (i_uses_rt_ID && (i_rd_EX == i_rt_ID)));
    // In STALL the EX slot holds a bubble, so hz is not consulted.
    stall_raw = (state_q == ST_STALL) || hz;
  end

  // All combinational outputs are held at zero while reset is asserted.
  always_comb begin
    o_forward_a   = i_reset ? fwd_a_raw : '0;
    o_forward_b   = i_reset ? fwd_b_raw : '0;
    o_stall       = i_reset && stall_raw;
    o_flush_ID_EX = i_reset && stall_raw;
    o_stall_count = count_q;
  end

  // The hazard cycle itself is the first stall cycle; STALL covers the
  // remaining LOAD_LAT-1 enabled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (hz && (LOAD_LAT > 1)) begin
            state_d = ST_STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
        default: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Clear beats increment; the count saturates at all ones.
  always_comb begin
    count_d = count_q;
    if (i_clr_count) begin
      count_d = '0;
    end else if (stall_raw && i_enable && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared inputs
  logic       rst_n, en, clr;
  logic [4:0] rs_ex, rt_ex, rs_id, rt_id, rd_ex;
  logic       uses_rs, uses_rt, memrd;
  // Instance A: 2 stages, legacy encoding, LOAD_LAT=3, CNT_W=4
  logic [9:0]  rd_a;
  logic [1:0]  rw_a;
  logic [1:0]  fa_a, fb_a;
  logic        st_a, fl_a;
  logic [3:0]  cnt_a;
  // Instance B: 3 stages, index encoding, LOAD_LAT=1, CNT_W=16
  logic [14:0] rd_b;
  logic [2:0]  rw_b;
  logic [1:0]  fa_b, fb_b;
  logic        st_b, fl_b;
  logic [15:0] cnt_b;

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_STAGES(2), .SEL_W(2), .LEGACY_ENC(1), .LOAD_LAT(3), .CNT_W(4)
  ) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en),
    .i_rs_EX(rs_ex), .i_rt_EX(rt_ex), .i_rd_stage(rd_a), .i_regwrite_stage(rw_a),
    .i_rs_ID(rs_id), .i_rt_ID(rt_id), .i_uses_rs_ID(uses_rs), .i_uses_rt_ID(uses_rt),
    .i_memread_EX(memrd), .i_rd_EX(rd_ex), .i_clr_count(clr),
    .o_forward_a(fa_a), .o_forward_b(fb_a), .o_stall(st_a), .o_flush_ID_EX(fl_a),
    .o_stall_count(cnt_a)
  );

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_STAGES(3), .SEL_W(2), .LEGACY_ENC(0), .LOAD_LAT(1), .CNT_W(16)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en),
    .i_rs_EX(rs_ex), .i_rt_EX(rt_ex), .i_rd_stage(rd_b), .i_regwrite_stage(rw_b),
    .i_rs_ID(rs_id), .i_rt_ID(rt_id), .i_uses_rs_ID(uses_rs), .i_uses_rt_ID(uses_rt),
    .i_memread_EX(memrd), .i_rd_EX(rd_ex), .i_clr_count(clr),
    .o_forward_a(fa_b), .o_forward_b(fb_b), .o_stall(st_b), .o_flush_ID_EX(fl_b),
    .o_stall_count(cnt_b)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: stall cycles still owed per instance, plus counters.
  int lat[2]        = '{3, 1};
  int cmax[2]       = '{15, 65535};
  int stall_left[2] = '{0, 0};
  int cnt_m[2]      = '{0, 0};
  bit stall_m[2];

  function automatic logic [1:0] fwd_model(input int nst, input bit legacy,
                                           input logic [14:0] rd_vec, input logic [2:0] rw_vec,
                                           input logic [4:0] src);
    logic [4:0] rd;
    for (int k = 0; k < nst; k++) begin
      rd = rd_vec[k*5 +: 5];
      if (rw_vec[k] && rd != 5'd0 && rd == src)
        return legacy ? ((k == 0) ? 2'b10 : 2'b01) : 2'(k + 1);
    end
    return 2'b00;
  endfunction

  function automatic bit hz_model();
    return memrd && rd_ex != 5'd0 &&
           ((uses_rs && rd_ex == rs_id) || (uses_rt && rd_ex == rt_id));
  endfunction

  // Sample at the falling edge and compare every output with the model.
  task automatic settle();
    logic [1:0] e_fa_a, e_fb_a, e_fa_b, e_fb_b;
    bit hz;
    @(negedge clk);
    hz = hz_model();
    for (int i = 0; i < 2; i++) stall_m[i] = rst_n && (stall_left[i] > 0 || hz);
    e_fa_a = rst_n ? fwd_model(2, 1'b1, {5'd0, rd_a}, {1'b0, rw_a}, rs_ex) : 2'b00;
    e_fb_a = rst_n ? fwd_model(2, 1'b1, {5'd0, rd_a}, {1'b0, rw_a}, rt_ex) : 2'b00;
    e_fa_b = rst_n ? fwd_model(3, 1'b0, rd_b, rw_b, rs_ex) : 2'b00;
    e_fb_b = rst_n ? fwd_model(3, 1'b0, rd_b, rw_b, rt_ex) : 2'b00;
    check_eq("a_fwd_a", fa_a, e_fa_a);
    check_eq("a_fwd_b", fb_a, e_fb_a);
    check_eq("a_stall", st_a, stall_m[0]);
    check_eq("a_flush", fl_a, stall_m[0]);
    check_eq("a_count", cnt_a, cnt_m[0]);
    check_eq("b_fwd_a", fa_b, e_fa_b);
    check_eq("b_fwd_b", fb_b, e_fb_b);
    check_eq("b_stall", st_b, stall_m[1]);
    check_eq("b_flush", fl_b, stall_m[1]);
    check_eq("b_count", cnt_b, cnt_m[1]);
  endtask

  // Advance the model over the rising edge with the inputs currently applied.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        stall_left[i] = 0;
        cnt_m[i]      = 0;
      end else begin
        if (clr) cnt_m[i] = 0;
        else if (stall_m[i] && en && cnt_m[i] < cmax[i]) cnt_m[i]++;
        if (en) begin
          if (stall_left[i] > 0) stall_left[i]--;
          else if (hz_model()) stall_left[i] = lat[i] - 1;
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; en = 1'b1; clr = 1'b0;
    rs_ex = '0; rt_ex = '0; rs_id = '0; rt_id = '0; rd_ex = '0;
    uses_rs = 1'b0; uses_rt = 1'b0; memrd = 1'b0;
    rd_a = '0; rw_a = '0; rd_b = '0; rw_b = '0;
  endtask

  task automatic set_hazard(input bit on);
    memrd = on; rd_ex = 5'd5; rs_id = 5'd5; uses_rs = on;
  endtask

  initial begin
    idle_inputs();
    // Reset with live inputs: combinational outputs must be forced low.
    rst_n = 1'b0;
    rd_a = {5'd8, 5'd8}; rw_a = 2'b11; rs_ex = 5'd8; set_hazard(1'b1);
    settle();
    check_eq("rst_fwd_a", fa_a, 0);
    check_eq("rst_stall", st_a, 0);
    tick();
    cycle();
    idle_inputs();
    settle();
    check_eq("rst_count", cnt_a, 0);
    tick();

    // Priority, legacy encoding
    rd_a = {5'd8, 5'd8}; rw_a = 2'b11; rs_ex = 5'd8; rt_ex = 5'd3;
    settle();
    check_eq("prio_mem_a", fa_a, 2'b10);
    check_eq("prio_none_b", fb_a, 2'b00);
    tick();
    rw_a = 2'b10;
    settle();
    check_eq("prio_wb_a", fa_a, 2'b01);
    tick();

    // Register 0 never forwarded
    idle_inputs();
    rw_a = 2'b11; rw_b = 3'b111;
    settle();
    check_eq("r0_a", fa_a, 0);
    check_eq("r0_b_b", fb_b, 0);
    tick();

    // Index encoding on three stages
    idle_inputs();
    rt_ex = 5'd12; rd_b = {5'd12, 5'd7, 5'd9}; rw_b = 3'b111;
    settle();
    check_eq("idx_stage2", fb_b, 2'd3);
    tick();
    rd_b = {5'd12, 5'd12, 5'd9};
    settle();
    check_eq("idx_stage1", fb_b, 2'd2);
    tick();

    // Load-use stall: three cycles on A, one on B
    idle_inputs();
    set_hazard(1'b1);
    settle();
    check_eq("lu_stall0", st_a, 1);
    tick();
    set_hazard(1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("lu_stall_n", st_a, 1);
      check_eq("lu_flush_n", fl_a, 1);
      tick();
    end
    settle();
    check_eq("lu_done", st_a, 0);
    check_eq("lu_count_a", cnt_a, 3);
    check_eq("lu_count_b", cnt_b, 1);
    tick();
    set_hazard(1'b1); uses_rs = 1'b0;
    settle();
    check_eq("lu_no_use", st_a, 0);
    tick();

    // Freeze in STALL with cnt=2, then reset aborts the stall
    idle_inputs();
    set_hazard(1'b1);
    cycle();
    set_hazard(1'b0); en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("frz_stall", st_a, 1);
      check_eq("frz_count", cnt_a, 4);
      tick();
    end
    rst_n = 1'b0;
    settle();
    check_eq("frz_rst_stall", st_a, 0);
    tick();
    rst_n = 1'b1; en = 1'b1;
    settle();
    check_eq("frz_post_stall", st_a, 0);
    check_eq("frz_post_count", cnt_a, 0);
    tick();

    // Saturation of the 4-bit counter, then clear beats increment
    idle_inputs();
    set_hazard(1'b1);
    for (int i = 0; i < 20; i++) cycle();
    settle();
    check_eq("sat_a", cnt_a, 15);
    check_eq("sat_b", cnt_b, 20);
    tick();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    settle();
    check_eq("clr_win_a", cnt_a, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      en      = ($urandom_range(0, 4) != 0);
      clr     = ($urandom_range(0, 29) == 0);
      rs_ex   = 5'($urandom_range(0, 3));
      rt_ex   = 5'($urandom_range(0, 3));
      rs_id   = 5'($urandom_range(0, 3));
      rt_id   = 5'($urandom_range(0, 3));
      rd_ex   = 5'($urandom_range(0, 3));
      uses_rs = 1'($urandom_range(0, 1));
      uses_rt = 1'($urandom_range(0, 1));
      memrd   = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) rd_a[k*5 +: 5] = 5'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) rd_b[k*5 +: 5] = 5'($urandom_range(0, 3));
      rw_a = 2'($urandom_range(0, 3));
      rw_b = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
